// File: rtl/nibble_serial_adder_if.sv
// Request/response bundle between the issue stage, the serial adder and writeback.
// Latency: none (wires only). Backpressure: valid/ready on both the request and the response side.
// master = issue/writeback side, slave = adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_overflow;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_overflow, out_zero
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit add/sub, one carry-lookahead nibble per cycle; NIBBLE_ADDER_FLAGS_EN adds overflow/zero flags.
// Latency: WIDTH/4 cycles from accept to out_valid; one operation per WIDTH/4+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no back-to-back accept.
module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
  logic [IW-1:0]    idx_q;
  logic             cy_q, carry_q;
  logic             accept, step, last;
  logic             in_rdy, out_vld;

  logic [3:0] na, nb, p, g, ns;
  logic [4:0] c;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign step   = (state_q == BUSY);
  assign last   = step && (idx_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)   state_d = BUSY;
      BUSY:    if (idx_q == LAST)  state_d = DONE;
      DONE:    if (bus.out_ready)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Handshake outputs decode straight from state
  always_comb begin
    in_rdy  = (state_q == IDLE);
    out_vld = (state_q == DONE);
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;

  // Carry-lookahead nibble slice on the current index
  always_comb begin
    na   = a_q[{idx_q, 2'b00} +: 4];
    nb   = b_q[{idx_q, 2'b00} +: 4];
    p    = na ^ nb;
    g    = na & nb;
    c[0] = cy_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & c[0]);
    ns   = p ^ c[3:0];
    res_d = res_q;
    res_d[{idx_q, 2'b00} +: 4] = ns;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.in_a;
      b_q   <= bus.in_sub ? ~bus.in_b : bus.in_b;
      cy_q  <= bus.in_sub;
      idx_q <= '0;
    end else if (step) begin
      res_q <= res_d;
      cy_q  <= c[4];
      idx_q <= idx_q + 1'b1;
      // Visible outputs only move on the edge that enters DONE
      if (last) begin
        sum_q   <= res_d;
        carry_q <= c[4];
      end
    end
  end

  assign bus.out_sum   = sum_q;
  assign bus.out_carry = carry_q;

`ifdef NIBBLE_ADDER_FLAGS_EN
  logic nz_q, ovf_q, zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      nz_q <= 1'b0;
    end else if (step) begin
      nz_q <= nz_q | (|ns);
      // Carry into vs. out of the sign bit gives signed overflow
      if (last) begin
        ovf_q  <= c[3] ^ c[4];
        zero_q <= ~(nz_q | (|ns));
      end
    end
  end

  assign bus.out_overflow = ovf_q;
  assign bus.out_zero     = zero_q;
`else
  assign bus.out_overflow = 1'b0;
  assign bus.out_zero     = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: directed corners, back-pressure, mid-op reset, random regression.
module tb_nibble_serial_adder;
  localparam int W = 32;
  localparam int N = W / 4;
`ifdef NIBBLE_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic [31:0]  acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   rand_stall = 1'b0;
  bit   prev_vld = 1'b0;
  exp_t sb[$];

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic ov, input logic z);
    exp_t e;
    e.sum   = s;
    e.carry = c;
    e.ovf   = ov & FLAGS;
    e.zero  = z & FLAGS;
    e.acc   = '0;
    return e;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    return mk(s[W-1:0], s[W], (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]), s[W-1:0] == '0);
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input exp_t e);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
    end else begin
      e.acc = 32'(cyc + 1);
      sb.push_back(e);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #2 bus.out_ready = r;
  endtask

  // Response monitor: latency on the rising out_valid, fields on the handshake
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (bus.out_valid && !prev_vld) begin
        if (sb.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
        else                chk("latency", 64'(cyc - int'(sb[0].acc)), 64'(N));
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("sum",   64'(bus.out_sum),      64'(e.sum));
        chk("carry", 64'(bus.out_carry),    64'(e.carry));
        chk("ovf",   64'(bus.out_overflow), 64'(e.ovf));
        chk("zero",  64'(bus.out_zero),     64'(e.zero));
      end
      prev_vld = bus.out_valid;
    end
  end

  initial forever begin
    @(posedge clk);
    #2 if (rand_stall) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d queued results outstanding", sb.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [W-1:0] ra, rb;
    logic         rs;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),     64'd1);
    chk("rst_out_valid", 64'(bus.out_valid),    64'd0);
    chk("rst_sum",       64'(bus.out_sum),      64'd0);
    chk("rst_carry",     64'(bus.out_carry),    64'd0);
    chk("rst_ovf",       64'(bus.out_overflow), 64'd0);
    chk("rst_zero",      64'(bus.out_zero),     64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    wait_drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    wait_drain();
    @(negedge clk);
    chk("hold_idle_sum", 64'(bus.out_sum),   64'h8000_0000);
    chk("hold_idle_vld", 64'(bus.out_valid), 64'd0);
    send(32'h0000_0007, 32'h0000_0005, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0, 1'b0));
    send(32'h8000_0000, 32'h0000_0001, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    send(32'h1234_5678, 32'h1234_5678, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    wait_drain();

    // Back-pressure with junk requests pulsed during BUSY and DONE
    set_ready(1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      bus.in_sub   = 1'($urandom_range(0, 1));
      t++;
    end
    if (t >= 50) chk("bp_valid_timeout", 64'd0, 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_vld",   64'(bus.out_valid), 64'd1);
      chk("bp_rdy",   64'(bus.in_ready),  64'd0);
      chk("bp_sum",   64'(bus.out_sum),   64'hFFFF_FFFE);
      chk("bp_carry", 64'(bus.out_carry), 64'd0);
      bus.in_valid = 1'b1;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    set_ready(1'b1);
    wait_drain();

    // Reset after three nibbles: no result may appear
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("midrst_sum",       64'(bus.out_sum),   64'd0);
    sb.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0, 1'b0));
    wait_drain();

    // Random regression with consumer stalls
    rand_stall = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = 32'h7FFF_FFFF;
        1:       ra = 32'h8000_0000;
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'h0000_0000;
        1:       rb = 32'h0000_0001;
        2:       rb = ra;
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, model(ra, rb, rs));
    end
    wait_drain();
    rand_stall = 1'b0;
    set_ready(1'b1);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
